// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage. Generates the PC stream, issues one instruction
// memory request at a time, and hands each {PC, instruction} pair to the
// fetch/decode pipeline register with a valid/ready handshake. A redirect
// from a later stage loads a new fetch PC and squashes any work that belongs
// to the old path. This includes a memory response that is still in flight:
// that response is waited for and then thrown away.
//
// Ports
//   clk_i             rising-edge clock
//   reset_i           asynchronous active-high reset
//   redirect_i        flush/redirect request; highest priority
//   redirect_pc_i     new fetch PC (bits [1:0] treated as zero)
//   imem_req_valid_o  memory request valid (only in REQ, never while
//                     redirect_i or reset_i is high)
//   imem_req_addr_o   memory request address (always the fetch PC register)
//   imem_req_ready_i  memory accepts the request this cycle
//   imem_rsp_valid_i  memory response valid (once per accepted request)
//   imem_rsp_data_i   instruction word from memory
//   valid_o           {PC_o, instruction_o} valid for downstream
//   instruction_o     fetched instruction
//   PC_o              PC of instruction_o
//   ready_i           downstream accepts the output this cycle
//
// Parameters
//   ResetPC           PC of the first fetch after reset (word aligned)
//   ClearDataOnReset  1: PC_o / instruction_o reset to zero
//                     0: output data registers carry no reset
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] ResetPC          = 64'h0000_0000_0000_0000,
    parameter bit          ClearDataOnReset = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,

    output logic        imem_req_valid_o,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,

    output logic        valid_o,
    output logic [31:0] instruction_o,
    output logic [63:0] PC_o,
    input  logic        ready_i
);

    // REQ  : request may be issued
    // WAIT : request accepted, waiting for its response
    // HOLD : instruction held on the outputs until accepted downstream
    // DROP : squashed request still in flight; swallow its response
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_inflight_pc;
    logic [63:0] r_out_pc;
    logic [31:0] r_out_instr;

    logic [63:0] w_reset_pc;
    logic [63:0] w_redirect_pc;
    logic        w_req_fire;
    logic        w_capture;
    logic        w_unused_pc_lsbs;

    // Fetch addresses are always word aligned; low bits of both the reset
    // value and the redirect target are forced to zero.
    assign w_reset_pc       = {ResetPC[63:2], 2'b00};
    assign w_redirect_pc    = {redirect_pc_i[63:2], 2'b00};
    assign w_unused_pc_lsbs = ^{redirect_pc_i[1:0], ResetPC[1:0]};

    // The handshake strobes depend combinationally on redirect_i: a redirect
    // must suppress a request or an output in the very cycle it is raised.
    // The state register comes out of reset as REQ, so the request strobe is
    // also gated by reset_i to stay quiet while reset is held.
    assign imem_req_valid_o = (r_state == ST_REQ) & ~redirect_i & ~reset_i;
    assign imem_req_addr_o  = r_pc;
    assign valid_o          = (r_state == ST_HOLD) & ~redirect_i;

    assign w_req_fire = imem_req_valid_o & imem_req_ready_i;

    // A response is kept only in WAIT and only if no redirect squashes it in
    // the same cycle.
    assign w_capture = (r_state == ST_WAIT) & imem_rsp_valid_i & ~redirect_i;

    // ------------------------------------------------------------------------
    // Control state, fetch PC and in-flight PC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= ST_REQ;
            r_pc          <= w_reset_pc;
            r_inflight_pc <= w_reset_pc;
        end else begin
            // A redirect overrides the sequential increment. The two never
            // coincide, because a redirect blocks the request handshake.
            if (redirect_i) begin
                r_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + 64'd4;
            end

            if (w_req_fire) begin
                r_inflight_pc <= r_pc;
            end

            case (r_state)
                ST_REQ: begin
                    if (w_req_fire) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        // A response in the redirect cycle can be dropped on
                        // the spot. Otherwise, wait for it in DROP.
                        r_state <= imem_rsp_valid_i ? ST_REQ : ST_DROP;
                    end else if (imem_rsp_valid_i) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // valid_o is low during a redirect, so ready_i alone
                    // completes the handshake only when no redirect is seen.
                    if (redirect_i || ready_i) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    // Only the stale response ends DROP. A further redirect
                    // here just updates the fetch PC above.
                    if (imem_rsp_valid_i) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output holding register. It is written only on a kept response, so it
    // holds steady for as long as the instruction waits in HOLD.
    // ------------------------------------------------------------------------
    generate
        if (ClearDataOnReset) begin : g_out_clear
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    r_out_instr <= 32'd0;
                    r_out_pc    <= 64'd0;
                end else if (w_capture) begin
                    r_out_instr <= imem_rsp_data_i;
                    r_out_pc    <= r_inflight_pc;
                end
            end
        end else begin : g_out_noclear
            always_ff @(posedge clk_i) begin
                if (w_capture) begin
                    r_out_instr <= imem_rsp_data_i;
                    r_out_pc    <= r_inflight_pc;
                end
            end
        end
    endgenerate

    assign instruction_o = r_out_instr;
    assign PC_o          = r_out_pc;

endmodule
